// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] AND      = 4'b0000;
   localparam logic [3:0] OR       = 4'b0001;
   localparam logic [3:0] ADD      = 4'b0010;
   localparam logic [3:0] SUB      = 4'b0110;
   localparam logic [3:0] LESSTHAN = 4'b0111;
   localparam logic [3:0] NOR      = 4'b1100;
   localparam logic [3:0] MUL      = 4'b1000;
   localparam logic [3:0] MULHU    = 4'b1001;
   localparam logic [3:0] DIV      = 4'b1010;
   localparam logic [3:0] REM      = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   function automatic logic is_multi(input logic [3:0] op);
      return (op == MUL) || (op == MULHU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/alu_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one hi:lo register pair.
// res_o = {hi, lo}: product for multiply, {remainder, quotient} for divide; last_o marks the final step.
module alu_iter #(
   parameter int W = 64
) (
   input  logic           clock_i,
   input  logic           reset_i,
   input  logic           load_i,
   input  logic           en_i,
   input  logic           div_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] res_o,
   output logic           last_o
);
   localparam int CW = $clog2(W);

   logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic          div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    sum, trial, diff;

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      b_d   = b_q;
      div_d = div_q;
      cnt_d = cnt_q;
      sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      trial = {hi_q, lo_q[W-1]};
      diff  = trial - {1'b0, b_q};
      if (load_i) begin
         hi_d  = '0;
         lo_d  = a_i;
         b_d   = b_i;
         div_d = div_i;
         cnt_d = CW'(W - 1);
      end else if (en_i) begin
         if (div_q) begin
            // Borrow out of bit W means the trial subtraction failed: restore.
            if (!diff[W]) begin
               hi_d = diff[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
               hi_d = trial[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b0};
            end
         end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
         end
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign res_o  = {hi_q, lo_q};
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU behind a Start/Busy/Done handshake; logic ops in 1 cycle, MUL/DIV family in W+1.
// Start is ignored while Busy; results and Overflow only change on the Done cycle or reset.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         Start,
   input  logic [3:0]   ALUctl,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] ALUout,
   output logic         Overflow,
   output logic         Zero,
   output logic         Busy,
   output logic         Done
);
   state_t         state_q, state_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [W-1:0]   aluout_q, aluout_d;
   logic           ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
   logic           iter_load, iter_en, iter_last;
   logic [2*W-1:0] iter_res;
   logic [W-1:0]   res, sum_w, dif_w;
   logic           res_ovf, b_zero;

   alu_iter #(.W(W)) u_iter (
      .clock_i (clock),
      .reset_i (reset),
      .load_i  (iter_load),
      .en_i    (iter_en),
      .div_i   (is_div(ALUctl)),
      .a_i     (A),
      .b_i     (B),
      .res_o   (iter_res),
      .last_o  (iter_last)
   );

   always_comb begin
      sum_w   = a_q + b_q;
      dif_w   = a_q - b_q;
      b_zero  = (b_q == '0);
      res     = '0;
      res_ovf = 1'b0;
      case (op_q)
         AND:      res = a_q & b_q;
         OR:       res = a_q | b_q;
         NOR:      res = ~(a_q | b_q);
         ADD: begin
            res     = sum_w;
            res_ovf = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
         end
         SUB: begin
            res     = dif_w;
            res_ovf = (a_q[W-1] != b_q[W-1]) && (dif_w[W-1] != a_q[W-1]);
         end
         LESSTHAN: res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         MUL: begin
            res     = iter_res[W-1:0];
            res_ovf = |iter_res[2*W-1:W];
         end
         MULHU:    res = iter_res[2*W-1:W];
         DIV: begin
            res     = b_zero ? '1 : iter_res[W-1:0];
            res_ovf = b_zero;
         end
         REM: begin
            res     = b_zero ? a_q : iter_res[2*W-1:W];
            res_ovf = b_zero;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      aluout_d  = aluout_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      iter_load = 1'b0;
      iter_en   = 1'b0;
      case (state_q)
         RUN: begin
            iter_en = 1'b1;
            if (iter_last) state_d = FIN;
         end
         FIN: begin
            aluout_d = res;
            ovf_d    = res_ovf;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: ;
      endcase
      // FIN of a single-cycle op has Busy=0, so a new request may overlap its write-back.
      if (Start && !busy_q) begin
         op_d      = ALUctl;
         a_d       = A;
         b_d       = B;
         busy_d    = is_multi(ALUctl);
         iter_load = is_multi(ALUctl);
         state_d   = is_multi(ALUctl) ? RUN : FIN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ALUout   = aluout_q;
   assign Overflow = ovf_q;
   assign Zero     = (aluout_q == '0);
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: hand-computed results, flags and Start-to-Done latencies.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 64;

   logic         clock = 1'b0;
   logic         reset;
   logic         Start;
   logic [3:0]   ALUctl;
   logic [W-1:0] A, B, ALUout;
   logic         Overflow, Zero, Busy, Done;

   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;
   int   n_done;
   logic busy_seen;

   always #5 clock = ~clock;

   alu_seq #(.W(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .Start    (Start),
      .ALUctl   (ALUctl),
      .A        (A),
      .B        (B),
      .ALUout   (ALUout),
      .Overflow (Overflow),
      .Zero     (Zero),
      .Busy     (Busy),
      .Done     (Done)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge just after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Start  = 1'b1;
      ALUctl = op;
      A      = a;
      B      = b;
      @(negedge clock);
      Start     = 1'b0;
      busy_seen = Busy;
   endtask

   // lat = number of rising edges after the accepting edge until Done is seen.
   task automatic wait_done(input string tag);
      lat = 0;
      while (1) begin
         @(negedge clock);
         lat++;
         if (Done || lat >= 200) break;
         if (Busy) busy_seen = 1'b1;
      end
      check({tag, "_done"}, W'(Done), W'(1));
   endtask

   initial begin
      reset  = 1'b1;
      Start  = 1'b0;
      ALUctl = 4'b0000;
      A      = '0;
      B      = '0;
      repeat (3) @(negedge clock);
      check("rst_aluout", ALUout, '0);
      check("rst_ovf", W'(Overflow), W'(0));
      check("rst_zero", W'(Zero), W'(1));
      check("rst_busy", W'(Busy), W'(0));
      check("rst_done", W'(Done), W'(0));
      reset = 1'b0;
      @(negedge clock);

      // Signed overflow on SUB, single-cycle latency, Busy never raised
      issue(SUB, 64'h8000_0000_0000_0000, 64'd1);
      wait_done("sub");
      check("sub_lat", W'(lat), W'(1));
      check("sub_out", ALUout, 64'h7FFF_FFFF_FFFF_FFFF);
      check("sub_ovf", W'(Overflow), W'(1));
      check("sub_zero", W'(Zero), W'(0));
      check("sub_busy", W'(busy_seen), W'(0));
      @(negedge clock);
      check("sub_pulse", W'(Done), W'(0));
      check("sub_hold", ALUout, 64'h7FFF_FFFF_FFFF_FFFF);

      // MUL with high half nonzero, then MULHU issued in the Done cycle
      issue(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      wait_done("mul");
      check("mul_lat", W'(lat), W'(65));
      check("mul_busy", W'(busy_seen), W'(1));
      check("mul_busy_end", W'(Busy), W'(0));
      check("mul_out", ALUout, 64'hFFFF_FFFF_FFFF_FFFE);
      check("mul_ovf", W'(Overflow), W'(1));
      issue(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      wait_done("mulhu");
      check("mulhu_lat", W'(lat), W'(65));
      check("mulhu_out", ALUout, 64'd1);
      check("mulhu_ovf", W'(Overflow), W'(0));

      // DIV then REM back-to-back
      @(negedge clock);
      issue(DIV, 64'd100, 64'd7);
      wait_done("div");
      check("div_lat", W'(lat), W'(65));
      check("div_out", ALUout, 64'd14);
      check("div_ovf", W'(Overflow), W'(0));
      issue(REM, 64'd100, 64'd7);
      wait_done("rem");
      check("rem_lat", W'(lat), W'(65));
      check("rem_out", ALUout, 64'd2);
      check("rem_ovf", W'(Overflow), W'(0));

      // Divide by zero
      @(negedge clock);
      issue(DIV, 64'd5, 64'd0);
      wait_done("div0");
      check("div0_out", ALUout, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div0_ovf", W'(Overflow), W'(1));
      issue(REM, 64'd5, 64'd0);
      wait_done("rem0");
      check("rem0_out", ALUout, 64'd5);
      check("rem0_ovf", W'(Overflow), W'(1));

      // MUL ignores a Start re-pulse and later operand changes while Busy
      @(negedge clock);
      issue(MUL, 64'd3, 64'd4);
      repeat (3) @(negedge clock);
      Start = 1'b1; ALUctl = ADD; A = 64'd7; B = 64'd9;
      @(negedge clock);
      Start = 1'b0; A = 64'd100; B = 64'd100;
      check("ign_hold", ALUout, 64'd5);
      check("ign_busy", W'(Busy), W'(1));
      wait_done("ign");
      check("ign_out", ALUout, 64'd12);
      check("ign_ovf", W'(Overflow), W'(0));

      // Reset in the middle of a MUL aborts it without a Done pulse
      @(negedge clock);
      issue(MUL, 64'd3, 64'd4);
      repeat (4) @(negedge clock);
      Start = 1'b1; ALUctl = ADD;
      @(negedge clock);
      Start = 1'b0; A = 64'd55; B = 64'd66;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy", W'(Busy), W'(0));
      check("abort_out", ALUout, '0);
      check("abort_zero", W'(Zero), W'(1));
      check("abort_done", W'(Done), W'(0));
      n_done = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clock);
         if (Done) n_done++;
      end
      check("abort_no_done", W'(n_done), W'(0));
      issue(ADD, 64'd2, 64'd3);
      wait_done("add");
      check("add_lat", W'(lat), W'(1));
      check("add_out", ALUout, 64'd5);

      // Remaining single-cycle ops and the undefined opcode
      issue(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      wait_done("addov");
      check("addov_out", ALUout, 64'h8000_0000_0000_0000);
      check("addov_ovf", W'(Overflow), W'(1));
      issue(LESSTHAN, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      wait_done("slt");
      check("slt_out", ALUout, 64'd1);
      check("slt_ovf", W'(Overflow), W'(0));
      issue(AND, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FF00);
      wait_done("and");
      check("and_out", ALUout, 64'h00F0_0000_00FF_1200);
      issue(OR, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0100);
      wait_done("or");
      check("or_out", ALUout, 64'hF000_0000_0000_0101);
      issue(NOR, 64'd0, 64'd0);
      wait_done("nor");
      check("nor_out", ALUout, 64'hFFFF_FFFF_FFFF_FFFF);
      check("nor_zero", W'(Zero), W'(0));
      issue(4'b0011, 64'd9, 64'd9);
      wait_done("undef");
      check("undef_lat", W'(lat), W'(1));
      check("undef_out", ALUout, '0);
      check("undef_zero", W'(Zero), W'(1));
      check("undef_ovf", W'(Overflow), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised multi-cycle ALU, the successor of the single-cycle combinational ALU. It keeps the existing opcode set and adds MUL, MULHU, DIV and REM, computed by an iterative one-bit-per-cycle engine. Results are registered and returned through a Start/Busy/Done handshake, so the datapath controller can issue any operation through one interface.

Parameters:
W, 64, operand/result width in bits (>= 4)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high
Start  in  1  issue request; sampled only when Busy=0
ALUctl  in  4  operation code, latched at accepted Start
A  in  W  operand A, latched at accepted Start
B  in  W  operand B, latched at accepted Start
ALUout  out  W  registered result, held until next Done
Overflow  out  1  registered status flag, held with ALUout
Zero  out  1  1 when ALUout == 0 (derived from ALUout register)
Busy  out  1  1 while an operation is in flight
Done  out  1  one-cycle pulse: ALUout/Overflow valid and updated

Behaviour:
- One clock domain, reset synchronous active-high.
- Reset values: ALUout=0, Overflow=0, Zero=1, Busy=0, Done=0, FSM=IDLE.
- Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MUL 1000, MULHU 1001, DIV 1010, REM 1011. Any other code gives result 0, Overflow 0, single-cycle latency.
- Accept rule: Start=1 and Busy=0 at edge k accepts the request. Start while Busy=1 is ignored; no queueing.
- Operands and ALUctl are captured at acceptance. Input changes afterwards have no effect.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/undefined): ALUout, Overflow and Done=1 are visible after edge k+1. Busy stays 0.
- Multi-cycle ops (MUL/MULHU/DIV/REM):
  - Busy=1 from after edge k until Done.
  - The engine iterates exactly W cycles.
  - Done=1 and Busy=0 after edge k+W+1, i.e. latency W+1.
- Back-to-back issue: Start may be asserted in the Done cycle; it is accepted because Busy=0.
- FSM states:
  - IDLE: accepted multi-cycle op -> RUN; accepted single-cycle op -> FIN.
  - RUN: decrements the iteration counter; at count 0 -> FIN.
  - FIN: writes results, pulses Done, -> IDLE.
- Arithmetic rules:
  - ADD/SUB: W-bit wrap. Overflow = signed two's-complement overflow.
  - SLT: signed compare, result 1 or 0 in bit 0.
  - AND/OR/NOR: Overflow=0.
  - MUL: low W bits of the unsigned 2W product. Overflow=1 iff the high W bits are nonzero.
  - MULHU: high W bits of the unsigned product. Overflow=0.
  - DIV/REM: unsigned restoring division.
  - Divide by zero: DIV returns all ones, REM returns A, Overflow=1.
  - Otherwise Overflow=0.
- Reset mid-operation: aborts immediately, no Done pulse, all outputs to their reset values. The next Start is accepted normally.
- Outputs never glitch between Done pulses. ALUout/Overflow change only in the cycle Done=1, or on reset.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (AND, OR, ADD, SUB, LESSTHAN, NOR, MUL, MULHU, DIV, REM);
  - FSM state encoding (IDLE, RUN, FIN).
- One sub-module, alu_iter: the W-cycle shift-add multiplier / restoring divider.
  - Inputs: load, mode, operands.
  - Outputs: 2W product or quotient/remainder, plus a last-iteration flag.
- Single-cycle ops stay inline in alu_seq.

Test Plan:
1. SUB, A=0x8000000000000000, B=1, Start pulse -> next cycle Done=1, ALUout=0x7FFFFFFFFFFFFFFF, Overflow=1, Zero=0, Busy never 1.
2. MUL, A=0xFFFFFFFFFFFFFFFF, B=2 -> Done exactly 65 cycles after Start, ALUout=0xFFFFFFFFFFFFFFFE, Overflow=1. MULHU, same operands -> ALUout=1, Overflow=0.
3. DIV, A=100, B=7 -> ALUout=14. REM, same operands -> ALUout=2. Overflow=0, latency 65 each; the REM Start is issued in the DIV Done cycle and accepted.
4. DIV, A=5, B=0 -> ALUout=0xFFFFFFFFFFFFFFFF, Overflow=1. REM, A=5, B=0 -> ALUout=5, Overflow=1.
5. MUL, A=3, B=4. Start re-pulsed with ADD at cycle 5 -> ignored. Operands changed at cycle 6 -> ignored. reset asserted at cycle 10 -> next cycle Busy=0, ALUout=0, Zero=1, no Done. New ADD, A=2, B=3 -> ALUout=5.
6. SLT, A=-1, B=1 -> ALUout=1. NOR, A=0, B=0 -> all ones, Zero=0. Undefined ALUctl=0011 -> ALUout=0, Zero=1, Overflow=0, latency 1.
